// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter sharing one FIFO write port among NREQ producers.
// A grant lasts until end of packet, BURST accepted words, or the owner drops its request.
module fifo_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDXW    = 2,
  parameter int BITSIZE = 44,
  parameter int BURST   = 4
) (
  input  logic                    clk,
  input  logic                    rstp,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BITSIZE-1:0] req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic [IDXW-1:0]         owner,
  output logic                    busy,
  input  logic                    fifo_fullp,
  output logic                    fifo_writep,
  output logic [BITSIZE-1:0]      fifo_data_in
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] BEAT_MAX = 8'(BURST - 1);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              busy_q, busy_d;

  logic [BITSIZE-1:0] words [NREQ];
  logic               accept;
  logic               found;
  logic [IDXW-1:0]    pick;
  logic [IDXW-1:0]    idx;
  logic [IDXW-1:0]    owner_inc;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words[i] = req_data[i*BITSIZE +: BITSIZE];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping from NREQ-1 back to 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDXW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign owner_inc = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  assign accept       = busy_q & req[owner_q] & ~fifo_fullp;
  assign ack          = accept ? (NREQ'(1) << owner_q) : '0;
  assign fifo_writep  = accept;
  assign fifo_data_in = busy_q ? words[owner_q] : '0;

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = OWN;
          owner_d    = pick;
          gnt_d      = NREQ'(1) << pick;
          busy_d     = 1'b1;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        // Abandon outranks accept; a stalled word (full) simply holds everything.
        if (!req[owner_q] || (accept && (req_last[owner_q] || beat_cnt_q == BEAT_MAX))) begin
          state_d    = IDLE;
          gnt_d      = '0;
          busy_d     = 1'b0;
          beat_cnt_d = '0;
          rr_ptr_d   = owner_inc;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus producer-driven
// sequences for burst limit, FIFO-full stall, abandon and asynchronous reset.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int IDXW = 2;
  localparam int BW   = 44;

  logic                 clk = 1'b0;
  logic                 rstp = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*BW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic [IDXW-1:0]      owner;
  logic                 busy;
  logic                 fifo_fullp = 1'b0;
  logic                 fifo_writep;
  logic [BW-1:0]        fifo_data_in;

  fifo_wr_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .BITSIZE(BW), .BURST(4)) dut (
    .clk(clk), .rstp(rstp), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .ack(ack), .owner(owner), .busy(busy),
    .fifo_fullp(fifo_fullp), .fifo_writep(fifo_writep), .fifo_data_in(fifo_data_in)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic        full;
    logic [7:0]  w;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        wr;
    logic [1:0]  owner;
    logic        busy;
    logic [43:0] data;
  } vec_t;

  localparam int NV = 20;
  vec_t vec [NV];

  logic [7:0]  pw   [NREQ][8];
  bit          pl   [NREQ][8];
  int          plen [NREQ];
  int          pptr [NREQ];
  logic [43:0] got [$];
  int          gorder [$];

  function automatic logic [43:0] D(input int o, input logic [7:0] w);
    return {4'(o), 32'h0, w};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic set_words(input logic [7:0] w);
    for (int i = 0; i < NREQ; i++) req_data[i*BW +: BW] = D(i, w);
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic f, input logic [7:0] w);
    @(negedge clk);
    req = r; req_last = l; fifo_fullp = f; set_words(w);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; req_last = '0; fifo_fullp = 1'b0;
    rstp = 1'b1;
    @(negedge clk);
    rstp = 1'b0;
  endtask

  task automatic clear_prod();
    for (int i = 0; i < NREQ; i++) begin plen[i] = 0; pptr[i] = 0; end
    got.delete();
    gorder.delete();
  endtask

  // Producers present their words and advance on ack; writes and grants are logged.
  task automatic run_prod(input int max_cyc, input logic [31:0] full_mask);
    bit          done;
    int          c;
    logic [3:0]  prev_gnt;
    logic        prev_full;
    prev_gnt  = gnt;
    prev_full = 1'b0;
    c         = 0;
    done      = 1'b0;
    while (!done && c < max_cyc) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        req[i]      = (pptr[i] < plen[i]);
        req_last[i] = req[i] && pl[i][pptr[i] % 8];
        req_data[i*BW +: BW] = D(i, req[i] ? pw[i][pptr[i] % 8] : 8'h00);
      end
      fifo_fullp = full_mask[c % 32];
      #1;
      if (gnt != 4'b0 && prev_gnt == 4'b0) gorder.push_back(int'(owner));
      if (fifo_fullp) begin
        chk($sformatf("stall c%0d no write", c), {fifo_writep, ack}, 5'b0);
      end
      if (prev_full && prev_gnt != 4'b0) chk($sformatf("stall c%0d gnt held", c), gnt, prev_gnt);
      if (fifo_writep) got.push_back(fifo_data_in);
      for (int i = 0; i < NREQ; i++) if (ack[i]) pptr[i]++;
      prev_gnt  = gnt;
      prev_full = fifo_fullp;
      c++;
      done = 1'b1;
      for (int i = 0; i < NREQ; i++) if (pptr[i] < plen[i]) done = 1'b0;
    end
    chk("producers finished within budget", done, 1'b1);
    @(negedge clk);
    req = '0; req_last = '0; fifo_fullp = 1'b0;
  endtask

  initial begin
    logic [43:0] exp_w [$];

    //               req     last    f     w      gnt     ack     wr    own   busy  data
    vec[0]  = '{4'b0010, 4'b0000, 1'b0, 8'hA1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 44'h0};
    vec[1]  = '{4'b0010, 4'b0000, 1'b0, 8'hA1, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1, D(1, 8'hA1)};
    vec[2]  = '{4'b0010, 4'b0000, 1'b0, 8'hA2, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1, D(1, 8'hA2)};
    vec[3]  = '{4'b0010, 4'b0010, 1'b0, 8'hA3, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1, D(1, 8'hA3)};
    vec[4]  = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 44'h0};
    vec[5]  = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 44'h0};
    vec[6]  = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, D(2, 8'hB0)};
    vec[7]  = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 44'h0};
    vec[8]  = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1, D(3, 8'hB0)};
    vec[9]  = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0, 44'h0};
    vec[10] = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1, D(0, 8'hB0)};
    vec[11] = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 44'h0};
    vec[12] = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1, D(1, 8'hB0)};
    vec[13] = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 44'h0};
    vec[14] = '{4'b1111, 4'b1111, 1'b0, 8'hB0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, D(2, 8'hB0)};
    vec[15] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 44'h0};
    vec[16] = '{4'b0001, 4'b0001, 1'b1, 8'hC0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 44'h0};
    vec[17] = '{4'b0001, 4'b0001, 1'b1, 8'hC0, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1, D(0, 8'hC0)};
    vec[18] = '{4'b0001, 4'b0001, 1'b0, 8'hC0, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1, D(0, 8'hC0)};
    vec[19] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 44'h0};

    // Reset state, held before any clock edge.
    #2;
    chk("reset gnt", gnt, 4'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset owner", owner, 2'd0);
    chk("reset writep", fifo_writep, 1'b0);
    chk("reset ack", ack, 4'b0);
    @(negedge clk);
    rstp = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cyc(vec[i].req, vec[i].last, vec[i].full, vec[i].w);
      chk($sformatf("row%0d gnt", i), gnt, vec[i].gnt);
      chk($sformatf("row%0d ack", i), ack, vec[i].ack);
      chk($sformatf("row%0d writep", i), fifo_writep, vec[i].wr);
      chk($sformatf("row%0d owner", i), owner, vec[i].owner);
      chk($sformatf("row%0d busy", i), busy, vec[i].busy);
      chk($sformatf("row%0d data", i), fifo_data_in, vec[i].data);
    end

    // Burst limit: requester 0 sends 6 words, requester 2 one word.
    do_reset();
    clear_prod();
    plen[0] = 6;
    for (int k = 0; k < 6; k++) begin pw[0][k] = 8'(k + 1); pl[0][k] = (k == 5); end
    plen[2] = 1; pw[2][0] = 8'h21; pl[2][0] = 1'b1;
    run_prod(30, 32'h0);
    exp_w = '{D(0, 8'h01), D(0, 8'h02), D(0, 8'h03), D(0, 8'h04),
              D(2, 8'h21), D(0, 8'h05), D(0, 8'h06)};
    chk("burst word count", got.size(), exp_w.size());
    for (int k = 0; k < exp_w.size(); k++)
      chk($sformatf("burst word%0d", k), (k < got.size()) ? got[k] : 44'hx, exp_w[k]);
    chk("burst grant count", gorder.size(), 3);
    chk("burst grant0", (gorder.size() > 0) ? gorder[0] : -1, 0);
    chk("burst grant1", (gorder.size() > 1) ? gorder[1] : -1, 2);
    chk("burst grant2", (gorder.size() > 2) ? gorder[2] : -1, 0);

    // FIFO full for three cycles after the first word.
    clear_prod();
    plen[1] = 3;
    pw[1][0] = 8'h31; pw[1][1] = 8'h32; pw[1][2] = 8'h33;
    pl[1][0] = 1'b0;  pl[1][1] = 1'b0;  pl[1][2] = 1'b1;
    run_prod(30, 32'h1C);
    exp_w = '{D(1, 8'h31), D(1, 8'h32), D(1, 8'h33)};
    chk("stall word count", got.size(), exp_w.size());
    for (int k = 0; k < exp_w.size(); k++)
      chk($sformatf("stall word%0d", k), (k < got.size()) ? got[k] : 44'hx, exp_w[k]);

    // Abandon: owner 3 drops req after one word; requester 1 waits.
    cyc(4'b1000, 4'b0000, 1'b0, 8'h41);
    chk("abandon arb gnt", gnt, 4'b0000);
    cyc(4'b1000, 4'b0000, 1'b0, 8'h41);
    chk("abandon owner3 gnt", gnt, 4'b1000);
    chk("abandon first word", {fifo_writep, fifo_data_in}, {1'b1, D(3, 8'h41)});
    cyc(4'b0010, 4'b0000, 1'b0, 8'h42);
    chk("abandon cycle gnt", gnt, 4'b1000);
    chk("abandon cycle no write", {fifo_writep, ack}, 5'b0);
    cyc(4'b0010, 4'b0010, 1'b0, 8'h51);
    chk("abandon idle gap", {busy, gnt}, 5'b0);
    cyc(4'b0010, 4'b0010, 1'b0, 8'h51);
    chk("abandon next gnt", gnt, 4'b0010);
    chk("abandon next ack", ack, 4'b0010);
    chk("abandon next data", fifo_data_in, D(1, 8'h51));

    // Async reset mid-packet with rr_ptr at 2.
    cyc(4'b0100, 4'b0000, 1'b0, 8'h61);
    chk("pre-reset idle", gnt, 4'b0000);
    cyc(4'b0100, 4'b0000, 1'b0, 8'h61);
    chk("pre-reset owner2 write", {gnt, fifo_writep}, {4'b0100, 1'b1});
    #2;
    rstp = 1'b1;
    req  = 4'b0110;
    req_last = 4'b0000;
    #1;
    chk("async reset gnt", gnt, 4'b0);
    chk("async reset busy", busy, 1'b0);
    chk("async reset writep", fifo_writep, 1'b0);
    chk("async reset ack", ack, 4'b0);
    chk("async reset owner", owner, 2'd0);
    @(negedge clk);
    rstp = 1'b0;
    #1;
    chk("post-reset idle", gnt, 4'b0);
    @(negedge clk);
    #1;
    chk("post-reset gnt from 0", gnt, 4'b0010);
    chk("post-reset owner", owner, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares the single write port of one 44-bit FIFO instance among NREQ producers.
- Grants one producer at a time and forwards its words to the FIFO write port, throttling on the FIFO full flag.
- Releases the grant at end of packet, at a burst limit, or when the owner abandons its request, so no producer can starve the others.
- Sits between the producer blocks and the FIFO.

Parameters:
- NREQ, 4, number of requesters.
- IDXW, 2, width of the requester index; must equal ceil(log2(NREQ)).
- BITSIZE, 44, data word width; must match the FIFO width.
- BURST, 4, maximum words accepted per grant; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstp  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; word valid while high.
- req_data  in  NREQ*BITSIZE  packed words; requester i occupies bits [i*BITSIZE +: BITSIZE].
- req_last  in  NREQ  marks requester i's current word as the last word of its packet.
- gnt  out  NREQ  registered one-hot grant, or all zeros.
- ack  out  NREQ  combinational; word of requester i accepted this cycle.
- owner  out  IDXW  registered index of the current or last owner.
- busy  out  1  registered; high while in the OWN state.
- fifo_fullp  in  1  FIFO full flag.
- fifo_writep  out  1  FIFO write enable.
- fifo_data_in  out  BITSIZE  FIFO write data.

Behaviour:
- Reset (asynchronous, effective immediately, no clock needed):
  - state=IDLE, gnt=0, owner=0, rr_ptr=0, beat_cnt=0, busy=0.
  - fifo_writep and ack are therefore 0.
- Accept condition: accept = busy & req[owner] & ~fifo_fullp.
  - ack[owner] = accept; all other ack bits are 0.
  - fifo_writep = accept.
  - fifo_data_in = req_data slice of owner, driven whenever busy, including when fifo_writep=0.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching from rr_ptr upward with wrap from NREQ-1 to 0.
  - At the next edge: owner=i, gnt=onehot(i), busy=1, beat_cnt=0, state=OWN.
  - No word is accepted in the arbitration cycle.
- State OWN, evaluated each edge in priority order:
  1. req[owner]=0 (abandon): release, with no word written that cycle.
  2. accept with req_last[owner]=1: release after the write.
  3. accept with beat_cnt==BURST-1: release after the write, even mid-packet. The requester must re-arbitrate for the remainder.
  4. accept otherwise: beat_cnt increments.
  5. fifo_fullp=1: hold; gnt, beat_cnt and owner are unchanged.
- Release, at the edge: gnt=0, busy=0, state=IDLE, beat_cnt=0, rr_ptr=owner+1 modulo NREQ. owner keeps its value.
- Handoff gap: exactly one IDLE cycle between grants.
  - Peak throughput is BURST words per BURST+1 cycles.
  - A lone requester re-wins immediately, since the search wraps back to it.
- Boundary cases:
  - req_last on a word that is stalled by fifo_fullp is ignored until that word is accepted.
  - Non-owner req and req_last are ignored.
  - fifo_fullp rising mid-burst stalls without losing the grant.
  - beat_cnt is 8 bits wide and never exceeds BURST-1.
- The arbiter does not track FIFO occupancy; fifo_fullp is the only backpressure.
- Reset during OWN: gnt drops asynchronously. A word partially presented is not written and the packet is lost; producers must restart after reset.

Test Plan:
- Single producer, 3-word packet:
  - Stimulus: req[1]=1 with data 0xA1,0xA2,0xA3; last on 0xA3; fifo_fullp=0.
  - Response: gnt=4'b0010 one cycle after req; ack and fifo_writep high for 3 consecutive cycles with data in order; gnt=0 the next cycle; rr_ptr=2.
- Round robin:
  - Stimulus: req=4'b1111 continuously, 1-word packets.
  - Response: owners 0,1,2,3,0 in order; each grant followed by one idle cycle.
- Burst limit:
  - Stimulus: BURST=4; requester 0 sends a 6-word packet; requester 2 also requesting.
  - Response: words 1-4 written; release; requester 2 is served; requester 0 regains the grant and writes words 5-6.
- FIFO full stall:
  - Stimulus: fifo_fullp=1 for 3 cycles after the first word.
  - Response: fifo_writep=0 and ack=0 during the stall; gnt held; no duplicated or dropped words; the full packet arrives in order.
- Abandon:
  - Stimulus: owner 3 drops req after 1 word without last.
  - Response: release the next edge with no write; rr_ptr=0; a pending requester 1 is granted after one IDLE cycle.
- Async reset:
  - Stimulus: assert rstp mid-packet, between clock edges.
  - Response: gnt, busy, fifo_writep and ack go to 0 immediately; after release of rstp, arbitration starts from requester 0.
